// File: rtl/aes_256_sched_if.sv
// Requester and response handshake bundle for aes_256_sched.
// The master modport is the requester/consumer side; slave is the scheduler.
interface aes_256_sched_if #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
);
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [128*NREQ-1:0] req_state;
   logic [256*NREQ-1:0] req_key;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [127:0]        rsp_data;
   logic [IDW-1:0]      rsp_id;

   modport master (
      output req_valid, req_state, req_key, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id
   );

   modport slave (
      input  req_valid, req_state, req_key, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id
   );
endinterface

// File: rtl/aes_256_sched.sv
// Round-robin scheduler feeding one non-stallable aes_256 pipeline, with a credit-sized result FIFO.
// Optional performance counters are enabled by defining AES256_SCHED_PERF_EN.
module aes_256_sched #(
   parameter int  NREQ       = 4,
   parameter int  CORE_LAT   = 29,
   parameter int  FIFO_DEPTH = 32,
   localparam int IDW        = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   aes_256_sched_if.slave    bus,
   output logic [127:0]      core_state,
   output logic [255:0]      core_key,
   input  logic [127:0]      core_out,
   output logic              busy
`ifdef AES256_SCHED_PERF_EN
   ,
   output logic [31:0]       perf_issued,
   output logic [31:0]       perf_stall
`endif
);

   localparam int OCCW = $clog2(FIFO_DEPTH + 1);
   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int CW   = PW + 1;

   logic [OCCW-1:0] occ;
   logic [IDW-1:0]  ptr;
   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  grant_idx;
   logic [IDW-1:0]  cand;
   logic            found;
   logic            accept;
   logic            pop;
   logic            issued;
   logic [IDW-1:0]  issued_id;
   logic [CORE_LAT-1:0] tag_v;
   logic [IDW-1:0]  tag_id [CORE_LAT];
   logic            fifo_wr;
   logic [127:0]    fifo_data [FIFO_DEPTH];
   logic [IDW-1:0]  fifo_id [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   fifo_cnt;

   // occ counts every result already promised a FIFO slot, so a full occ blocks new grants
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      cand      = '0;
      found     = 1'b0;
      if (rst_n && (occ < OCCW'(FIFO_DEPTH))) begin
         for (int i = 1; i <= NREQ; i++) begin
            cand = IDW'((int'(ptr) + i) % NREQ);
            if (!found && bus.req_valid[cand]) begin
               found           = 1'b1;
               grant[cand]     = 1'b1;
               grant_idx       = cand;
            end
         end
      end
   end

   assign accept        = |grant;
   assign pop           = bus.rsp_valid & bus.rsp_ready;
   assign bus.req_ready = grant;
   assign busy          = (occ != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ        <= '0;
         ptr        <= IDW'(NREQ - 1);
         core_state <= '0;
         core_key   <= '0;
         issued     <= 1'b0;
         issued_id  <= '0;
      end else begin
         occ       <= occ + OCCW'(accept) - OCCW'(pop);
         issued    <= accept;
         issued_id <= grant_idx;
         if (accept) begin
            ptr        <= grant_idx;
            core_state <= bus.req_state[128*grant_idx +: 128];
            core_key   <= bus.req_key[256*grant_idx +: 256];
         end
      end
   end

   // The tag pipe mirrors the core latency; only its valid bits decide what reaches the FIFO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_v <= '0;
         for (int i = 0; i < CORE_LAT; i++) begin
            tag_id[i] <= '0;
         end
      end else begin
         tag_v[0]  <= issued;
         tag_id[0] <= issued_id;
         for (int i = 1; i < CORE_LAT; i++) begin
            tag_v[i]  <= tag_v[i-1];
            tag_id[i] <= tag_id[i-1];
         end
      end
   end

   assign fifo_wr = tag_v[CORE_LAT-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (fifo_wr) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         fifo_cnt <= fifo_cnt + CW'(fifo_wr) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_wr) begin
         fifo_data[wr_ptr] <= core_out;
         fifo_id[wr_ptr]   <= tag_id[CORE_LAT-1];
      end
   end

   // Storage is unreset, so the head is forced to zero whenever nothing is buffered
   assign bus.rsp_valid = (fifo_cnt != '0);
   assign bus.rsp_data  = bus.rsp_valid ? fifo_data[rd_ptr] : '0;
   assign bus.rsp_id    = bus.rsp_valid ? fifo_id[rd_ptr] : '0;

`ifdef AES256_SCHED_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_issued <= '0;
         perf_stall  <= '0;
      end else begin
         if (accept) begin
            perf_issued <= perf_issued + 32'd1;
         end
         if ((|bus.req_valid) && !accept) begin
            perf_stall <= perf_stall + 32'd1;
         end
      end
   end
`endif

endmodule
